// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one valid/ready data-memory port between the IFU (word
// fetches) and the LSU (byte/half/word loads and stores), round-robin on a tie.
// Latency: accept at edge 0, rvalid in cycle 3 with zero-wait memory; faulty
// requests answer in cycle 1 without touching memory.
// Backpressure: one transaction in flight; ready only in IDLE; the loser keeps
// its valid high; responses cannot be stalled.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   ifu_valid/addr/ready           IFU fetch request handshake
//   ifu_rvalid/rdata/err           IFU response (one-cycle pulse, held data)
//   lsu_valid/we/ctr/addr/wdata    LSU request; ctr selects size and sign
//   lsu_ready                      LSU request accepted
//   lsu_rvalid/rdata/err           LSU response (rdata extended, 0 for stores)
//   mem_valid/ready                memory request handshake
//   mem_we/addr/wdata/wmask        word-aligned request with byte enables
//   mem_rvalid/rdata               memory read data / write ack
module mem_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        ifu_valid,
   input  logic [31:0] ifu_addr,
   output logic        ifu_ready,
   output logic        ifu_rvalid,
   output logic [31:0] ifu_rdata,
   output logic        ifu_err,
   input  logic        lsu_valid,
   input  logic        lsu_we,
   input  logic [2:0]  lsu_ctr,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   output logic        lsu_ready,
   output logic        lsu_rvalid,
   output logic [31:0] lsu_rdata,
   output logic        lsu_err,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      r_state;
   state_t      w_next;

   // Arbitration and latched request
   logic        r_last_lsu;   // 1 = LSU was granted last; resets to IFU
   logic        r_owner_lsu;  // owner of the transaction in flight
   logic        r_we;
   logic [2:0]  r_ctr;
   logic [1:0]  r_off;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [3:0]  r_mem_wmask;

   // Registered responses, held until the owner's next response
   logic [31:0] r_ifu_rdata;
   logic        r_ifu_err;
   logic [31:0] r_lsu_rdata;
   logic        r_lsu_err;

   logic        w_idle;
   logic        w_gnt_lsu;
   logic        w_gnt_ifu;
   logic        w_accept;
   logic [31:0] w_req_addr;
   logic        w_req_we;
   logic [2:0]  w_req_ctr;
   logic        w_ctr_bad;
   logic        w_lsu_fault;
   logic        w_ifu_fault;
   logic        w_req_fault;
   logic [3:0]  w_st_mask;
   logic [31:0] w_st_dat;
   logic [31:0] w_ld_shift;
   logic [31:0] w_ld_dat;

   // ------------------------------------------------------------------
   // Grant: a lone requester wins; on a tie the one not granted last wins.
   // ------------------------------------------------------------------
   assign w_idle    = (r_state == S_IDLE);
   assign w_gnt_lsu = w_idle & lsu_valid & (~ifu_valid | ~r_last_lsu);
   assign w_gnt_ifu = w_idle & ifu_valid & ~w_gnt_lsu;
   assign w_accept  = w_gnt_lsu | w_gnt_ifu;

   // IFU requests are treated as aligned word loads.
   assign w_req_addr = w_gnt_lsu ? lsu_addr : ifu_addr;
   assign w_req_we   = w_gnt_lsu & lsu_we;
   assign w_req_ctr  = w_gnt_lsu ? lsu_ctr : 3'b010;

   // ------------------------------------------------------------------
   // Fault detection: illegal size code or misaligned half/word access.
   // ------------------------------------------------------------------
   assign w_ctr_bad   = (lsu_ctr == 3'b011) | (lsu_ctr == 3'b110) |
                        (lsu_ctr == 3'b111);
   assign w_lsu_fault = w_ctr_bad |
                        ((lsu_ctr[1:0] == 2'b01) & lsu_addr[0]) |
                        ((lsu_ctr[1:0] == 2'b10) & (lsu_addr[1:0] != 2'b00));
   assign w_ifu_fault = (ifu_addr[1:0] != 2'b00);
   assign w_req_fault = w_gnt_lsu ? w_lsu_fault : w_ifu_fault;

   // ------------------------------------------------------------------
   // Store encoding: replicate the data across the word so the byte
   // enables alone pick the lane.
   // ------------------------------------------------------------------
   always_comb begin
      w_st_mask = 4'b1111;
      w_st_dat  = lsu_wdata;
      case (lsu_ctr[1:0])
         2'b00: begin
            w_st_mask = 4'b0001 << lsu_addr[1:0];
            w_st_dat  = {4{lsu_wdata[7:0]}};
         end
         2'b01: begin
            w_st_mask = 4'b0011 << lsu_addr[1:0];
            w_st_dat  = {2{lsu_wdata[15:0]}};
         end
         default: begin
            w_st_mask = 4'b1111;
            w_st_dat  = lsu_wdata;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Load decode: shift the addressed lane down, then sign/zero extend.
   // ------------------------------------------------------------------
   assign w_ld_shift = mem_rdata >> {r_off, 3'b000};

   always_comb begin
      w_ld_dat = w_ld_shift;
      case (r_ctr)
         3'b000:  w_ld_dat = {{24{w_ld_shift[7]}},  w_ld_shift[7:0]};
         3'b001:  w_ld_dat = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
         3'b100:  w_ld_dat = {24'h000000, w_ld_shift[7:0]};
         3'b101:  w_ld_dat = {16'h0000,   w_ld_shift[15:0]};
         default: w_ld_dat = w_ld_shift;
      endcase
      if (r_we) begin
         w_ld_dat = 32'h0000_0000;
      end
   end

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM next state and handshake outputs. Outputs depend only on the
   // state register and request valids, so reset drops them at once.
   // ------------------------------------------------------------------
   always_comb begin
      w_next     = r_state;
      ifu_ready  = 1'b0;
      lsu_ready  = 1'b0;
      mem_valid  = 1'b0;
      ifu_rvalid = 1'b0;
      lsu_rvalid = 1'b0;
      case (r_state)
         S_IDLE: begin
            ifu_ready = w_gnt_ifu;
            lsu_ready = w_gnt_lsu;
            if (w_accept) begin
               w_next = w_req_fault ? S_RESP : S_ISSUE;
            end
         end
         S_ISSUE: begin
            mem_valid = 1'b1;
            if (mem_ready) begin
               w_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               w_next = S_RESP;
            end
         end
         S_RESP: begin
            ifu_rvalid = ~r_owner_lsu;
            lsu_rvalid = r_owner_lsu;
            w_next     = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Request latch and response capture. Response registers are written
   // on the edge that enters RESP, so data and rvalid appear together.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_lsu  <= 1'b0;
         r_owner_lsu <= 1'b0;
         r_we        <= 1'b0;
         r_ctr       <= 3'b000;
         r_off       <= 2'b00;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'h0000_0000;
         r_mem_wdata <= 32'h0000_0000;
         r_mem_wmask <= 4'b0000;
         r_ifu_rdata <= 32'h0000_0000;
         r_ifu_err   <= 1'b0;
         r_lsu_rdata <= 32'h0000_0000;
         r_lsu_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_last_lsu  <= w_gnt_lsu;
            r_owner_lsu <= w_gnt_lsu;
            r_we        <= w_req_we;
            r_ctr       <= w_req_ctr;
            r_off       <= w_req_addr[1:0];
            r_mem_we    <= w_req_we;
            r_mem_addr  <= {w_req_addr[31:2], 2'b00};
            r_mem_wdata <= w_req_we ? w_st_dat : 32'h0000_0000;
            r_mem_wmask <= w_req_we ? w_st_mask : 4'b0000;
            // Faulty requests skip memory and answer on the next cycle.
            if (w_req_fault) begin
               if (w_gnt_lsu) begin
                  r_lsu_err   <= 1'b1;
                  r_lsu_rdata <= 32'h0000_0000;
               end else begin
                  r_ifu_err   <= 1'b1;
                  r_ifu_rdata <= 32'h0000_0000;
               end
            end
         end
         if ((r_state == S_WAIT) && mem_rvalid) begin
            if (r_owner_lsu) begin
               r_lsu_rdata <= w_ld_dat;
               r_lsu_err   <= 1'b0;
            end else begin
               r_ifu_rdata <= mem_rdata;
               r_ifu_err   <= 1'b0;
            end
         end
      end
   end

   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_wmask = r_mem_wmask;
   assign ifu_rdata = r_ifu_rdata;
   assign ifu_err   = r_ifu_err;
   assign lsu_rdata = r_lsu_rdata;
   assign lsu_err   = r_lsu_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against hand-computed values.
// Latency: zero-wait memory model unless a test stalls mem_ready.
// Backpressure: requests are held until ready, then dropped.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        ifu_valid;
   logic [31:0] ifu_addr;
   logic        ifu_ready;
   logic        ifu_rvalid;
   logic [31:0] ifu_rdata;
   logic        ifu_err;
   logic        lsu_valid;
   logic        lsu_we;
   logic [2:0]  lsu_ctr;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic        lsu_ready;
   logic        lsu_rvalid;
   logic [31:0] lsu_rdata;
   logic        lsu_err;
   logic        mem_valid;
   logic        mem_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int n_chk = 0;
   int n_err = 0;

   mem_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .ifu_valid  (ifu_valid),
      .ifu_addr   (ifu_addr),
      .ifu_ready  (ifu_ready),
      .ifu_rvalid (ifu_rvalid),
      .ifu_rdata  (ifu_rdata),
      .ifu_err    (ifu_err),
      .lsu_valid  (lsu_valid),
      .lsu_we     (lsu_we),
      .lsu_ctr    (lsu_ctr),
      .lsu_addr   (lsu_addr),
      .lsu_wdata  (lsu_wdata),
      .lsu_ready  (lsu_ready),
      .lsu_rvalid (lsu_rvalid),
      .lsu_rdata  (lsu_rdata),
      .lsu_err    (lsu_err),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wmask  (mem_wmask),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        is_lsu;
      logic        we;
      logic [2:0]  ctr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] word;       // memory word returned
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [31:0] exp_maddr;
      logic [3:0]  exp_mask;
      logic [31:0] exp_mwdata;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issues one request (caller is just after a negedge) and observes
   // eight cycles after acceptance.
   task automatic do_req(input logic is_lsu, input logic we,
                         input logic [2:0] ctr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] word,
                         output logic rdy, output int lat, output int n_rv,
                         output logic [31:0] rdata, output logic err,
                         output int n_mv, output logic m_we,
                         output logic [31:0] m_addr, output logic [31:0] m_wdata,
                         output logic [3:0] m_mask);
      logic rv;
      lat = 0; n_rv = 0; n_mv = 0; rdata = '0; err = 1'b0;
      m_we = 1'b0; m_addr = '0; m_wdata = '0; m_mask = '0;
      mem_rdata = word;
      if (is_lsu) begin
         lsu_valid = 1'b1; lsu_we = we; lsu_ctr = ctr;
         lsu_addr = addr; lsu_wdata = wdata;
      end else begin
         ifu_valid = 1'b1; ifu_addr = addr;
      end
      #1;
      rdy = is_lsu ? lsu_ready : ifu_ready;
      @(posedge clk);
      @(negedge clk);
      ifu_valid = 1'b0;
      lsu_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) @(negedge clk);
         if (mem_valid) begin
            if (n_mv == 0) begin
               m_we = mem_we; m_addr = mem_addr;
               m_wdata = mem_wdata; m_mask = mem_wmask;
            end
            n_mv++;
         end
         rv = is_lsu ? lsu_rvalid : ifu_rvalid;
         if (rv) begin
            if (n_rv == 0) begin
               lat = k;
               rdata = is_lsu ? lsu_rdata : ifu_rdata;
               err = is_lsu ? lsu_err : ifu_err;
            end
            n_rv++;
         end
      end
   endtask

   vec_t        v[14];
   logic        rdy;
   int          lat, n_rv, n_mv;
   logic [31:0] rdata, m_addr, m_wdata;
   logic        err, m_we;
   logic [3:0]  m_mask;
   logic [3:0]  gseq;
   int          ng, n_both, n_irv, n_lrv, n_stall_mv, n_late;

   initial begin
      //          name        lsu we  ctr     addr          wdata         word          exp_rdata     err maddr         mask     mwdata
      v[0]  = '{"ifu_fetch",  0, 0, 3'b010, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 32'h8000_0004, 4'b0000, 32'h0};
      v[1]  = '{"sb_off3",    1, 1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 32'h0,        32'h0,        0, 32'h8000_0000, 4'b1000, 32'hA5A5_A5A5};
      v[2]  = '{"lh_off2",    1, 0, 3'b001, 32'h8000_0002, 32'h0,        32'h80F1_7F22, 32'hFFFF_80F1, 0, 32'h8000_0000, 4'b0000, 32'h0};
      v[3]  = '{"lhu_off2",   1, 0, 3'b101, 32'h8000_0002, 32'h0,        32'h80F1_7F22, 32'h0000_80F1, 0, 32'h8000_0000, 4'b0000, 32'h0};
      v[4]  = '{"lb_off3",    1, 0, 3'b000, 32'h8000_0003, 32'h0,        32'h80F1_7F22, 32'hFFFF_FF80, 0, 32'h8000_0000, 4'b0000, 32'h0};
      v[5]  = '{"lbu_off1",   1, 0, 3'b100, 32'h8000_0001, 32'h0,        32'h80F1_7F22, 32'h0000_007F, 0, 32'h8000_0000, 4'b0000, 32'h0};
      v[6]  = '{"lw",         1, 0, 3'b010, 32'h0000_0010, 32'h0,        32'h1234_5678, 32'h1234_5678, 0, 32'h0000_0010, 4'b0000, 32'h0};
      v[7]  = '{"sh_off2",    1, 1, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 32'h0,        32'h0,        0, 32'h0000_1000, 4'b1100, 32'hBEEF_BEEF};
      v[8]  = '{"sw",         1, 1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 32'h0,        32'h0,        0, 32'h0000_0020, 4'b1111, 32'hCAFE_F00D};
      v[9]  = '{"sbu_off1",   1, 1, 3'b100, 32'h0000_0041, 32'h0000_005A, 32'h0,        32'h0,        0, 32'h0000_0040, 4'b0010, 32'h5A5A_5A5A};
      v[10] = '{"lh_mis",     1, 0, 3'b001, 32'h8000_0001, 32'h0,        32'h0,        32'h0,        1, 32'h0,         4'b0000, 32'h0};
      v[11] = '{"ifu_mis",    0, 0, 3'b010, 32'h8000_0002, 32'h0,        32'h0,        32'h0,        1, 32'h0,         4'b0000, 32'h0};
      v[12] = '{"ctr_011",    1, 0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        32'h0,        1, 32'h0,         4'b0000, 32'h0};
      v[13] = '{"lw_mis",     1, 1, 3'b010, 32'h0000_0006, 32'h1,        32'h0,        32'h0,        1, 32'h0,         4'b0000, 32'h0};

      rst = 1'b1;
      ifu_valid = 1'b0; ifu_addr = '0;
      lsu_valid = 1'b0; lsu_we = 1'b0; lsu_ctr = 3'b000;
      lsu_addr = '0; lsu_wdata = '0;
      mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = '0;

      // ---- reset state ----
      repeat (2) @(negedge clk);
      chk("rst_ctl", {30'h0, ifu_ready, ifu_rvalid}, 32'h0);
      chk("rst_lsu_ctl", {29'h0, lsu_ready, lsu_rvalid, lsu_err}, 32'h0);
      chk("rst_mem_ctl", {26'h0, mem_valid, mem_we, mem_wmask}, 32'h0);
      chk("rst_rdata", ifu_rdata | lsu_rdata | {31'h0, ifu_err}, 32'h0);
      chk("rst_maddr", mem_addr | mem_wdata, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // ---- contention: both valid every cycle, LSU wins first tie ----
      ifu_valid = 1'b1; ifu_addr = 32'h0000_0100;
      lsu_valid = 1'b1; lsu_we = 1'b0; lsu_ctr = 3'b010;
      lsu_addr = 32'h0000_0200; mem_rdata = 32'h1111_1111;
      ng = 0; n_both = 0; n_irv = 0; n_lrv = 0; gseq = '0;
      for (int i = 0; i < 16; i++) begin
         #1;
         if (ifu_ready && lsu_ready) n_both++;
         if ((ifu_ready || lsu_ready) && ng < 4) begin
            gseq[3 - ng] = lsu_ready;
            ng++;
         end
         if (ifu_rvalid) n_irv++;
         if (lsu_rvalid) n_lrv++;
         @(negedge clk);
      end
      ifu_valid = 1'b0; lsu_valid = 1'b0;
      chk("rr_grants", ng, 4);
      chk("rr_order", {28'h0, gseq}, 32'h0000_000A);
      chk("rr_both_ready", n_both, 0);
      chk("rr_ifu_resp", n_irv, 2);
      chk("rr_lsu_resp", n_lrv, 2);
      @(negedge clk);

      // ---- table-driven single transactions ----
      for (int i = 0; i < 14; i++) begin
         do_req(v[i].is_lsu, v[i].we, v[i].ctr, v[i].addr, v[i].wdata, v[i].word,
                rdy, lat, n_rv, rdata, err, n_mv, m_we, m_addr, m_wdata, m_mask);
         chk({v[i].name, "_ready"}, rdy, 1);
         chk({v[i].name, "_lat"}, lat, v[i].exp_err ? 1 : 3);
         chk({v[i].name, "_npulse"}, n_rv, 1);
         chk({v[i].name, "_err"}, err, v[i].exp_err);
         chk({v[i].name, "_nmemvalid"}, n_mv, v[i].exp_err ? 0 : 1);
         if (!v[i].exp_err) begin
            chk({v[i].name, "_rdata"}, rdata, v[i].exp_rdata);
            chk({v[i].name, "_mwe"}, m_we, v[i].we);
            chk({v[i].name, "_maddr"}, m_addr, v[i].exp_maddr);
            chk({v[i].name, "_mask"}, m_mask, v[i].exp_mask);
            if (v[i].we) chk({v[i].name, "_mwdata"}, m_wdata, v[i].exp_mwdata);
         end
      end

      // ---- stalled memory, then async reset mid-transaction ----
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      lsu_valid = 1'b1; lsu_we = 1'b0; lsu_ctr = 3'b010;
      lsu_addr = 32'h0000_0300; mem_rdata = 32'h5555_AAAA;
      @(posedge clk);
      @(negedge clk);
      lsu_valid = 1'b0;
      n_stall_mv = 0;
      for (int k = 0; k < 5; k++) begin
         if (mem_valid && mem_addr == 32'h0000_0300) n_stall_mv++;
         @(negedge clk);
      end
      chk("stall_memvalid_held", n_stall_mv, 5);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_memvalid", mem_valid, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mem_ready = 1'b1; mem_rvalid = 1'b1;   // late response must be ignored
      n_late = 0;
      for (int k = 0; k < 4; k++) begin
         if (lsu_rvalid || ifu_rvalid || mem_valid) n_late++;
         @(negedge clk);
      end
      chk("late_rvalid_ignored", n_late, 0);

      do_req(1'b1, 1'b0, 3'b100, 32'h0000_0302, 32'h0, 32'h5555_AAAA,
             rdy, lat, n_rv, rdata, err, n_mv, m_we, m_addr, m_wdata, m_mask);
      chk("post_rst_lat", lat, 3);
      chk("post_rst_rdata", rdata, 32'h0000_0055);
      chk("post_rst_err", err, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single data-memory port between the instruction-fetch unit (IFU, word reads only) and the load/store unit (LSU, byte/half/word loads and stores). Arbitrates with round-robin on contention, keeps one transaction in flight, and issues it over a valid/ready memory handshake. It also builds the byte write mask, replicates store data, and aligns and extends load data. It sits between the IFU/LSU and the DPI-backed memory model.

## Interface
Parameters: none (32-bit address and data fixed).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- ifu_valid  in  1  IFU fetch request
- ifu_addr  in  32  fetch address
- ifu_ready  out  1  IFU request accepted this cycle
- ifu_rvalid  out  1  one-cycle response pulse
- ifu_rdata  out  32  fetched word
- ifu_err  out  1  misaligned fetch; valid with ifu_rvalid
- lsu_valid  in  1  LSU request
- lsu_we  in  1  1 = store, 0 = load
- lsu_ctr  in  3  000 = byte signed, 001 = half signed, 010 = word, 100 = byte unsigned, 101 = half unsigned
- lsu_addr  in  32  byte address
- lsu_wdata  in  32  store data, right-aligned
- lsu_ready  out  1  LSU request accepted this cycle
- lsu_rvalid  out  1  one-cycle response pulse (loads and stores)
- lsu_rdata  out  32  extended load data; 0 for stores
- lsu_err  out  1  misaligned address or illegal ctr; valid with lsu_rvalid
- mem_valid  out  1  memory request
- mem_ready  in  1  memory accepts the request
- mem_we  out  1  write enable
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  replicated store data
- mem_wmask  out  4  byte enables
- mem_rvalid  in  1  read data / write ack from memory
- mem_rdata  in  32  raw memory word

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE: a grant is computed combinationally.
  - If only one requester is valid, that requester wins.
  - If both are valid, the requester not granted last wins. The last-grant flop resets to IFU, so LSU wins the first tie.
  - The winner's ready is driven to 1. The request is latched (addr, we, ctr, wdata, owner) and the last-grant flop is updated.
  - Next state is ISSUE, or RESP with err=1 if the request is faulty.
- Fault conditions, which issue no memory access:
  - IFU: addr[1:0] != 0.
  - LSU half: addr[0] = 1.
  - LSU word: addr[1:0] != 0.
  - LSU ctr in {011, 110, 111}.
- ISSUE: mem_valid = 1 with stable outputs until mem_ready. When mem_ready is seen, go to WAIT.
- WAIT: when mem_rvalid is seen, capture the processed data and go to RESP.
- RESP: assert the owner's rvalid for exactly one cycle, then return to IDLE. The response has no backpressure.
- Store encoding, with off = addr[1:0]:
  - Byte: mask = 4'b0001 << off; wdata = {4{wdata[7:0]}}.
  - Half: mask = 4'b0011 << off; wdata = {2{wdata[15:0]}}.
  - Word: mask = 4'b1111.
  - Loads drive mask = 0.
- Load decode: s = mem_rdata >> (8*off), then extend according to lsu_ctr (sign or zero, byte/half; word passes through). The IFU receives mem_rdata unchanged.
- mem_rvalid and mem_ready outside ISSUE/WAIT are ignored.

## Timing
- Reset values: all outputs 0; state IDLE; last-grant = IFU.
- Async rst mid-transaction drops mem_valid immediately and discards any pending response. A late mem_rvalid after reset is ignored.
- ready is asserted only in IDLE and is combinational from valid. Request fields are sampled on the same edge.
- Minimum latency (zero-wait memory, mem_ready and mem_rvalid both 1 on first sight):
  - Accept at edge 0, ISSUE in cycle 1, WAIT in cycle 2, rvalid in cycle 3.
  - Throughput is one transaction per 4 cycles.
- Fault latency: accept at edge 0, rvalid with err in cycle 1.
- rdata/err are registered and hold their value until the next response. rvalid is high for 1 cycle only.
- At most one outstanding transaction. A requester that is not granted keeps its valid asserted.

## Test plan
- IFU fetch at 0x8000_0004, memory word 0xDEADBEEF, zero-wait -> ifu_rvalid in cycle 3, ifu_rdata = 0xDEADBEEF, ifu_err = 0, mem_wmask = 0.
- LSU byte store at 0x8000_0003 of wdata 0x0000_00A5 -> mem_wmask = 1000, mem_wdata = 0xA5A5A5A5, mem_addr = 0x8000_0000, lsu_rvalid pulse with lsu_rdata = 0.
- LSU loads of word 0x80F1_7F22 at offset 2: ctr 001 -> 0xFFFF80F1; ctr 101 -> 0x000080F1; ctr 000 at offset 3 -> 0xFFFFFF80; ctr 100 at offset 1 -> 0x0000007F.
- IFU and LSU valid every cycle -> grants alternate LSU, IFU, LSU, IFU…; no requester starves; exactly one mem_valid transaction at a time.
- Misaligned: LSU half at 0x…01 and IFU at 0x…02 -> err = 1, rvalid 1 cycle after accept, mem_valid never asserts. ctr = 011 -> lsu_err = 1.
- Stall memory with mem_ready = 0 for 5 cycles, then assert rst for 1 cycle -> mem_valid drops asynchronously, no rvalid is produced, a following mem_rvalid is ignored, and the next request completes normally.
